// File: rtl/encoder_position_tracker_if.sv
// Link between the SPI absolute-encoder reader and its poll scheduler.
// The tracker is master: it issues enc_req and receives the angle.
interface encoder_position_tracker_if #(
  parameter int ANGLE_W = 19
);
  logic               enc_req;
  logic [ANGLE_W-1:0] angle;
  logic               angle_valid;

  modport master (
    output enc_req,
    input  angle,
    input  angle_valid
  );

  modport slave (
    input  enc_req,
    output angle,
    output angle_valid
  );
endinterface

// File: rtl/encoder_position_tracker.sv
// Polls the encoder reader, unwraps the single-turn angle into a
// multi-turn position, and flags implausible jumps and dead readers.
module encoder_position_tracker #(
  parameter int ANGLE_W     = 19,
  parameter int TURN_W      = 13,
  parameter int POLL_DIV    = 100000,
  parameter int TIMEOUT_CYC = 10000,
  parameter int MAX_STEP    = 16384
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      err_clr,
  encoder_position_tracker_if.master rd,
  output logic [ANGLE_W+TURN_W-1:0] pos,
  output logic [TURN_W-1:0]         turns,
  output logic [ANGLE_W-1:0]        vel,
  output logic                      pos_valid,
  output logic                      initialized,
  output logic                      jump_err,
  output logic                      timeout_err,
  output logic [7:0]                reject_cnt
);

  localparam int PCW = $clog2(POLL_DIV);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int POS_W = ANGLE_W + TURN_W;
  localparam logic signed [ANGLE_W:0] STEP_P =
    (ANGLE_W+1)'(MAX_STEP);
  localparam logic signed [ANGLE_W:0] STEP_N = -STEP_P;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    UPDATE
  } state_t;

  state_t             state;
  logic [PCW-1:0]     poll_cnt;
  logic [TCW-1:0]     tmo;
  logic [ANGLE_W-1:0] lat;
  logic [ANGLE_W-1:0] prev_angle;
  logic [ANGLE_W-1:0] delta;
  logic signed [ANGLE_W:0] dx;
  logic               step_ok;
  logic               tick;
  logic [7:0]         rej_next;

  assign turns = pos[POS_W-1:ANGLE_W];

  always_comb begin
    delta    = lat - prev_angle;
    // one extra bit so -2^(ANGLE_W-1) still compares correctly
    dx       = {delta[ANGLE_W-1], delta};
    step_ok  = (dx <= STEP_P) && (dx >= STEP_N);
    tick     = enable && (poll_cnt == PCW'(POLL_DIV - 1));
    rej_next = err_clr ? 8'd1 :
               (reject_cnt == 8'hFF) ? 8'hFF :
               reject_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
    end else if (enable) begin
      if (tick) poll_cnt <= '0;
      else      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd.enc_req  <= 1'b0;
      tmo         <= '0;
      lat         <= '0;
      prev_angle  <= '0;
      pos         <= '0;
      vel         <= '0;
      pos_valid   <= 1'b0;
      initialized <= 1'b0;
      jump_err    <= 1'b0;
      timeout_err <= 1'b0;
      reject_cnt  <= '0;
    end else begin
      rd.enc_req <= 1'b0;
      pos_valid  <= 1'b0;
      if (err_clr) begin
        jump_err    <= 1'b0;
        timeout_err <= 1'b0;
        reject_cnt  <= '0;
      end
      unique case (state)
        IDLE: begin
          if (tick) begin
            state      <= REQ;
            rd.enc_req <= 1'b1;
          end
        end
        REQ: begin
          tmo   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (rd.angle_valid) begin
            lat   <= rd.angle;
            state <= UPDATE;
          end else if (tmo == TCW'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        UPDATE: begin
          state <= IDLE;
          if (!initialized) begin
            pos         <= {{TURN_W{1'b0}}, lat};
            vel         <= '0;
            prev_angle  <= lat;
            initialized <= 1'b1;
            pos_valid   <= 1'b1;
          end else if (step_ok) begin
            pos        <= pos +
              {{TURN_W{delta[ANGLE_W-1]}}, delta};
            vel        <= delta;
            prev_angle <= lat;
            pos_valid  <= 1'b1;
          end else begin
            jump_err   <= 1'b1;
            reject_cnt <= rej_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_position_tracker.sv
// Directed bench for encoder_position_tracker with a short poll period
// and short timeout so every scenario fits in a few hundred cycles.
module tb_encoder_position_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] pos;
  logic [12:0] turns;
  logic [18:0] vel;
  logic        pos_valid;
  logic        initialized;
  logic        jump_err;
  logic        timeout_err;
  logic [7:0]  reject_cnt;

  int total = 0;
  int bad = 0;

  encoder_position_tracker_if #(.ANGLE_W(19)) rd ();

  encoder_position_tracker #(
    .ANGLE_W(19),
    .TURN_W(13),
    .POLL_DIV(10),
    .TIMEOUT_CYC(20),
    .MAX_STEP(16384)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .err_clr(err_clr),
    .rd(rd),
    .pos(pos),
    .turns(turns),
    .vel(vel),
    .pos_valid(pos_valid),
    .initialized(initialized),
    .jump_err(jump_err),
    .timeout_err(timeout_err),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rd.enc_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // entered in the REQ cycle; leaves in the cycle pos_valid is due
  task automatic respond(input logic [18:0] a,
                         output logic pv1,
                         output logic pv2);
    @(posedge clk);
    #1;
    rd.angle = a;
    rd.angle_valid = 1'b1;
    @(posedge clk);
    #1;
    rd.angle_valid = 1'b0;
    pv1 = pos_valid;
    @(posedge clk);
    #1;
    pv2 = pos_valid;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (pos !== 32'd0 || vel !== 19'd0) begin
      bad++;
      $display("FAIL reset_pos pos=%0d vel=%0d want 0", pos, vel);
    end
    total++;
    if ({pos_valid, initialized, rd.enc_req} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got %b want 000",
               {pos_valid, initialized, rd.enc_req});
    end
    total++;
    if ({jump_err, timeout_err} !== 2'b00 ||
        reject_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_err je=%b te=%b rc=%0d want 0",
               jump_err, timeout_err, reject_cnt);
    end
  endtask

  task automatic test_first_req;
    bit early;
    logic pv1, pv2;
    early = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rd.enc_req !== 1'b0 || pos !== 32'd0 ||
          pos_valid !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL pre_req_quiet got activity want none");
    end
    @(posedge clk);
    #1;
    total++;
    if (rd.enc_req !== 1'b1) begin
      bad++;
      $display("FAIL first_req enc_req=%b want 1", rd.enc_req);
    end
    respond(19'd100, pv1, pv2);
    total++;
    if (pv1 !== 1'b0 || pv2 !== 1'b1) begin
      bad++;
      $display("FAIL seed_latency pv1=%b pv2=%b want 0 1", pv1, pv2);
    end
    total++;
    if (pos !== 32'd100 || vel !== 19'd0 || initialized !== 1'b1) begin
      bad++;
      $display("FAIL seed pos=%0d vel=%0d init=%b want 100 0 1",
               pos, vel, initialized);
    end
  endtask

  task automatic test_step;
    bit ok;
    logic pv1, pv2;
    wait_req(ok);
    respond(19'd150, pv1, pv2);
    total++;
    if (!ok || pv2 !== 1'b1 || pos !== 32'd150 || vel !== 19'd50) begin
      bad++;
      $display("FAIL step ok=%b pv=%b pos=%0d vel=%0d want 1 1 150 50",
               ok, pv2, pos, vel);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic pv1, pv2;
    do_reset();
    wait_req(ok);
    respond(19'd524280, pv1, pv2);
    total++;
    if (!ok || pos !== 32'd524280 || turns !== 13'd0) begin
      bad++;
      $display("FAIL wrap_seed ok=%b pos=%0d turns=%0d want 524280 0",
               ok, pos, turns);
    end
    wait_req(ok);
    respond(19'd5, pv1, pv2);
    total++;
    if (pv2 !== 1'b1 || pos !== 32'd524293 ||
        vel !== 19'd13 || turns !== 13'd1) begin
      bad++;
      $display("FAIL wrap_fwd pos=%0d vel=%0d turns=%0d want 524293 13 1",
               pos, vel, turns);
    end
    wait_req(ok);
    respond(19'd524280, pv1, pv2);
    total++;
    if (pv2 !== 1'b1 || pos !== 32'd524280 ||
        vel !== 19'h7FFF3 || turns !== 13'd0) begin
      bad++;
      $display("FAIL wrap_bwd pos=%0d vel=%h turns=%0d want 524280 7fff3 0",
               pos, vel, turns);
    end
  endtask

  task automatic test_jump;
    bit ok;
    logic pv1, pv2;
    do_reset();
    wait_req(ok);
    respond(19'd1000, pv1, pv2);
    total++;
    if (!ok || pos !== 32'd1000) begin
      bad++;
      $display("FAIL jump_seed pos=%0d want 1000", pos);
    end
    wait_req(ok);
    respond(19'd17385, pv1, pv2);
    total++;
    if ((pv1 | pv2) !== 1'b0 || jump_err !== 1'b1 ||
        reject_cnt !== 8'd1 || pos !== 32'd1000) begin
      bad++;
      $display("FAIL jump_rej pv=%b je=%b rc=%0d pos=%0d want 0 1 1 1000",
               pv1 | pv2, jump_err, reject_cnt, pos);
    end
    wait_req(ok);
    respond(19'd17384, pv1, pv2);
    total++;
    if (pv2 !== 1'b1 || pos !== 32'd17384 || vel !== 19'd16384) begin
      bad++;
      $display("FAIL jump_edge pv=%b pos=%0d vel=%0d want 1 17384 16384",
               pv2, pos, vel);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    total++;
    if (jump_err !== 1'b0 || reject_cnt !== 8'd0) begin
      bad++;
      $display("FAIL err_clr je=%b rc=%0d want 0 0",
               jump_err, reject_cnt);
    end
    wait_req(ok);
    respond(19'd999, pv1, pv2);
    total++;
    if ((pv1 | pv2) !== 1'b0 || jump_err !== 1'b1 ||
        reject_cnt !== 8'd1 || pos !== 32'd17384) begin
      bad++;
      $display("FAIL jump_neg pv=%b je=%b rc=%0d pos=%0d want 0 1 1 17384",
               pv1 | pv2, jump_err, reject_cnt, pos);
    end
  endtask

  task automatic test_enable_off;
    bit ok;
    bit seen;
    logic pv1, pv2;
    wait_req(ok);
    enable = 1'b0;
    respond(19'd17400, pv1, pv2);
    total++;
    if (!ok || pv2 !== 1'b1 || pos !== 32'd17400 || vel !== 19'd16) begin
      bad++;
      $display("FAIL en_off_finish pv=%b pos=%0d vel=%0d want 1 17400 16",
               pv2, pos, vel);
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (rd.enc_req !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL en_off_idle enc_req seen=1 want 0");
    end
    enable = 1'b1;
  endtask

  task automatic test_timeout;
    bit ok;
    int first;
    int nxt;
    first = 0;
    nxt = 0;
    wait_req(ok);
    total++;
    if (!ok || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_start ok=%b te=%b want 1 0", ok, timeout_err);
    end
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (timeout_err === 1'b1 && first == 0) first = i;
    end
    total++;
    if (first != 21) begin
      bad++;
      $display("FAIL tmo_cycle got %0d want 21", first);
    end
    for (int i = 26; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rd.enc_req === 1'b1) begin
        nxt = i;
        break;
      end
    end
    total++;
    if (nxt != 30 || pos !== 32'd17400) begin
      bad++;
      $display("FAIL tmo_next req_at=%0d pos=%0d want 30 17400", nxt, pos);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    logic pv1, pv2;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (pos !== 32'd0 || initialized !== 1'b0 ||
        timeout_err !== 1'b0 || jump_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid pos=%0d init=%b te=%b je=%b want 0",
               pos, initialized, timeout_err, jump_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd.angle = 19'd5000;
    rd.angle_valid = 1'b1;
    @(posedge clk);
    #1;
    rd.angle_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (pos_valid !== 1'b0 || pos !== 32'd0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL late_valid accepted=1 want 0");
    end
    wait_req(ok);
    respond(19'd777, pv1, pv2);
    total++;
    if (!ok || pv2 !== 1'b1 || pos !== 32'd777 || vel !== 19'd0) begin
      bad++;
      $display("FAIL reseed pv=%b pos=%0d vel=%0d want 1 777 0",
               pv2, pos, vel);
    end
  endtask

  initial begin
    rd.angle = '0;
    rd.angle_valid = 1'b0;
    test_reset();
    test_first_req();
    test_step();
    test_wrap();
    test_jump();
    test_enable_off();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
